mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage.sv | 152 +++++++++++++++
 tb/tb_mem_access_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Purpose  : Pipeline MEM stage: data memory handshake, branch select, MEM/WB.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] branch_address,
    input  logic [31:0] alu_result,
    input  logic [31:0] write_data,
    input  logic [4:0]  rd,
    input  logic        zeroflag,
    input  logic        RegWrite,
    input  logic        MemToReg,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        Branch,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        pc_src,
    output logic [31:0] pc_branch,
    output logic [31:0] wb_read_data,
    output logic [31:0] wb_alu_result,
    output logic [4:0]  wb_rd,
    output logic        wb_RegWrite,
    output logic        wb_MemToReg
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic [31:0] wb_read_data_q, wb_read_data_d;
    logic [31:0] wb_alu_result_q, wb_alu_result_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_regwrite_q, wb_regwrite_d;
    logic        wb_memtoreg_q, wb_memtoreg_d;
    logic        w_stall;
    logic        w_mem_op;

    assign w_mem_op  = MemRead | MemWrite;
    assign pc_src    = Branch & zeroflag;
    assign pc_branch = branch_address;
    // The state register already sits in IDLE during reset, so the raw
    // IDLE-with-op stall has to be masked explicitly.
    assign stall     = reset & w_stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            dmem_req_q      <= 1'b0;
            dmem_we_q       <= 1'b0;
            dmem_addr_q     <= 32'd0;
            dmem_wdata_q    <= 32'd0;
            wb_read_data_q  <= 32'd0;
            wb_alu_result_q <= 32'd0;
            wb_rd_q         <= 5'd0;
            wb_regwrite_q   <= 1'b0;
            wb_memtoreg_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            dmem_req_q      <= dmem_req_d;
            dmem_we_q       <= dmem_we_d;
            dmem_addr_q     <= dmem_addr_d;
            dmem_wdata_q    <= dmem_wdata_d;
            wb_read_data_q  <= wb_read_data_d;
            wb_alu_result_q <= wb_alu_result_d;
            wb_rd_q         <= wb_rd_d;
            wb_regwrite_q   <= wb_regwrite_d;
            wb_memtoreg_q   <= wb_memtoreg_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        dmem_req_d      = dmem_req_q;
        dmem_we_d       = dmem_we_q;
        dmem_addr_d     = dmem_addr_q;
        dmem_wdata_d    = dmem_wdata_q;
        wb_read_data_d  = wb_read_data_q;
        wb_alu_result_d = wb_alu_result_q;
        wb_rd_d         = wb_rd_q;
        wb_regwrite_d   = wb_regwrite_q;
        wb_memtoreg_d   = wb_memtoreg_q;
        w_stall         = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_mem_op) begin
                    w_stall       = 1'b1;
                    state_d       = ACCESS;
                    dmem_req_d    = 1'b1;
                    dmem_we_d     = MemWrite;
                    dmem_addr_d   = alu_result;
                    dmem_wdata_d  = write_data;
                    wb_regwrite_d = 1'b0;
                    wb_memtoreg_d = 1'b0;
                end else begin
                    wb_read_data_d  = 32'd0;
                    wb_alu_result_d = alu_result;
                    wb_rd_d         = rd;
                    wb_regwrite_d   = RegWrite;
                    wb_memtoreg_d   = MemToReg;
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    state_d         = IDLE;
                    dmem_req_d      = 1'b0;
                    dmem_we_d       = 1'b0;
                    wb_read_data_d  = dmem_we_q ? 32'd0 : dmem_rdata;
                    wb_alu_result_d = alu_result;
                    wb_rd_d         = rd;
                    wb_regwrite_d   = RegWrite;
                    wb_memtoreg_d   = MemToReg;
                end else begin
                    w_stall       = 1'b1;
                    wb_regwrite_d = 1'b0;
                    wb_memtoreg_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dmem_req      = dmem_req_q;
    assign dmem_we       = dmem_we_q;
    assign dmem_addr     = dmem_addr_q;
    assign dmem_wdata    = dmem_wdata_q;
    assign wb_read_data  = wb_read_data_q;
    assign wb_alu_result = wb_alu_result_q;
    assign wb_rd         = wb_rd_q;
    assign wb_RegWrite   = wb_regwrite_q;
    assign wb_MemToReg   = wb_memtoreg_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Purpose  : Directed scoreboard bench for mem_access_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    logic        clk;
    logic        reset;
    logic [31:0] branch_address, alu_result, write_data;
    logic [4:0]  rd;
    logic        zeroflag, RegWrite, MemToReg, MemRead, MemWrite, Branch;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall, pc_src;
    logic [31:0] pc_branch, wb_read_data, wb_alu_result;
    logic [4:0]  wb_rd;
    logic        wb_RegWrite, wb_MemToReg;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        rw;
        logic        m2r;
    } wb_t;

    wb_t sb[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  stall_cycles;

    mem_access_stage dut (
        .clk            (clk),
        .reset          (reset),
        .branch_address (branch_address),
        .alu_result     (alu_result),
        .write_data     (write_data),
        .rd             (rd),
        .zeroflag       (zeroflag),
        .RegWrite       (RegWrite),
        .MemToReg       (MemToReg),
        .MemRead        (MemRead),
        .MemWrite       (MemWrite),
        .Branch         (Branch),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_ack       (dmem_ack),
        .dmem_rdata     (dmem_rdata),
        .stall          (stall),
        .pc_src         (pc_src),
        .pc_branch      (pc_branch),
        .wb_read_data   (wb_read_data),
        .wb_alu_result  (wb_alu_result),
        .wb_rd          (wb_rd),
        .wb_RegWrite    (wb_RegWrite),
        .wb_MemToReg    (wb_MemToReg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [4:0] e_rd, input logic [31:0] e_alu,
                            input logic [31:0] e_rdata, input logic e_rw, input logic e_m2r);
        wb_t e;
        e.rd = e_rd; e.alu = e_alu; e.rdata = e_rdata; e.rw = e_rw; e.m2r = e_m2r;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        wb_t e;
        n_tests++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL %s_sb_empty: observed %0d expected >0", tag, sb.size());
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_wb_rd"},         32'(wb_rd),        32'(e.rd));
            chk({tag, "_wb_alu"},        wb_alu_result,     e.alu);
            chk({tag, "_wb_rdata"},      wb_read_data,      e.rdata);
            chk({tag, "_wb_RegWrite"},   32'(wb_RegWrite),  32'(e.rw));
            chk({tag, "_wb_MemToReg"},   32'(wb_MemToReg),  32'(e.m2r));
        end
    endtask

    task automatic clear_inputs();
        branch_address = 32'd0; alu_result = 32'd0; write_data = 32'd0; rd = 5'd0;
        zeroflag = 1'b0; RegWrite = 1'b0; MemToReg = 1'b0; MemRead = 1'b0;
        MemWrite = 1'b0; Branch = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_dmem_req"},   32'(dmem_req),    32'd0);
        chk({tag, "_dmem_we"},    32'(dmem_we),     32'd0);
        chk({tag, "_dmem_addr"},  dmem_addr,        32'd0);
        chk({tag, "_dmem_wdata"}, dmem_wdata,       32'd0);
        chk({tag, "_wb_rdata"},   wb_read_data,     32'd0);
        chk({tag, "_wb_alu"},     wb_alu_result,    32'd0);
        chk({tag, "_wb_rd"},      32'(wb_rd),       32'd0);
        chk({tag, "_wb_rw"},      32'(wb_RegWrite), 32'd0);
        chk({tag, "_wb_m2r"},     32'(wb_MemToReg), 32'd0);
        chk({tag, "_stall"},      32'(stall),       32'd0);
    endtask

    initial begin
        // Reset asserted with random inputs, checked before any clock edge
        reset          = 1'b0;
        branch_address = $urandom; alu_result = $urandom; write_data = $urandom;
        rd = 5'($urandom); zeroflag = 1'b1; Branch = 1'b1;
        RegWrite = 1'b1; MemToReg = 1'b1; MemRead = 1'b1; MemWrite = 1'b1;
        dmem_ack = 1'b1; dmem_rdata = $urandom;
        #2;
        check_all_zero("reset");
        chk("reset_pc_src",    32'(pc_src), 32'd1);
        chk("reset_pc_branch", pc_branch,   branch_address);
        clear_inputs();
        step();
        reset = 1'b1;

        // ALU op: one-cycle pass-through
        RegWrite = 1'b1; rd = 5'd5; alu_result = 32'h10;
        #1;
        chk("alu_stall", 32'(stall), 32'd0);
        push_exp(5'd5, 32'h10, 32'd0, 1'b1, 1'b0);
        step();
        pop_check("alu");
        clear_inputs();

        // Load with ack in the third ACCESS cycle
        stall_cycles = 0;
        MemRead = 1'b1; MemToReg = 1'b1; RegWrite = 1'b1; rd = 5'd7;
        alu_result = 32'h100; write_data = 32'hAAAA_5555;
        push_exp(5'd7, 32'h100, 32'hDEADBEEF, 1'b1, 1'b1);
        #1;
        chk("ld_idle_stall", 32'(stall), 32'd1);
        if (stall) stall_cycles++;
        step();
        chk("ld_req",       32'(dmem_req),    32'd1);
        chk("ld_addr",      dmem_addr,        32'h100);
        chk("ld_we",        32'(dmem_we),     32'd0);
        chk("ld_bubble_rw", 32'(wb_RegWrite), 32'd0);
        chk("ld_hold_alu",  wb_alu_result,    32'h10);
        if (stall) stall_cycles++;
        step();
        chk("ld_acc2_stall", 32'(stall),    32'd1);
        chk("ld_acc2_req",   32'(dmem_req), 32'd1);
        chk("ld_acc2_addr",  dmem_addr,     32'h100);
        if (stall) stall_cycles++;
        step();
        dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
        #1;
        chk("ld_ack_stall", 32'(stall), 32'd0);
        if (stall) stall_cycles++;
        chk("ld_stall_cycles", 32'(stall_cycles), 32'd3);
        step();
        dmem_ack = 1'b0; dmem_rdata = 32'h0BAD_0BAD;
        pop_check("ld");
        chk("ld_req_drop", 32'(dmem_req), 32'd0);
        clear_inputs();

        // Store with ack in the first ACCESS cycle
        MemWrite = 1'b1; write_data = 32'h1234; alu_result = 32'h200; rd = 5'd3;
        push_exp(5'd3, 32'h200, 32'd0, 1'b0, 1'b0);
        #1;
        chk("st_idle_stall", 32'(stall), 32'd1);
        step();
        chk("st_we",    32'(dmem_we),  32'd1);
        chk("st_wdata", dmem_wdata,    32'h1234);
        chk("st_req",   32'(dmem_req), 32'd1);
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
        #1;
        chk("st_ack_stall", 32'(stall), 32'd0);
        step();
        dmem_ack = 1'b0;
        pop_check("st");
        chk("st_we_drop", 32'(dmem_we), 32'd0);
        clear_inputs();

        // Branch select is purely combinational
        Branch = 1'b1; zeroflag = 1'b1; branch_address = 32'h40;
        #1;
        chk("br_taken",  32'(pc_src), 32'd1);
        chk("br_target", pc_branch,   32'h40);
        zeroflag = 1'b0;
        #1;
        chk("br_not_taken", 32'(pc_src), 32'd0);
        clear_inputs();

        // Ack while idle must not load read data
        RegWrite = 1'b1; rd = 5'd11; alu_result = 32'h77; dmem_ack = 1'b1; dmem_rdata = 32'h55;
        push_exp(5'd11, 32'h77, 32'd0, 1'b1, 1'b0);
        #1;
        chk("idle_ack_stall", 32'(stall), 32'd0);
        step();
        pop_check("idle_ack");
        clear_inputs();

        // Reset mid-ACCESS, then a stray ack
        MemRead = 1'b1; RegWrite = 1'b1; alu_result = 32'h180; rd = 5'd4;
        step();
        chk("mid_req", 32'(dmem_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("mid_rst");
        clear_inputs();
        #1;
        reset = 1'b1;
        RegWrite = 1'b1; rd = 5'd9; alu_result = 32'h300;
        dmem_ack = 1'b1; dmem_rdata = 32'hBADBAD00;
        push_exp(5'd9, 32'h300, 32'd0, 1'b1, 1'b0);
        step();
        pop_check("stray");
        chk("stray_req", 32'(dmem_req), 32'd0);
        dmem_ack = 1'b0;
        #1;
        chk("stray_idle_stall", 32'(stall), 32'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
